// File: rtl/adder_result_checker.sv
// Checks an adder under test against golden sum/carry values, one vector per cycle.
// Latency: a vector accepted on edge k is compared and counted on edge k+1.
// Backpressure: in_ready is high only while RUN still needs vectors; it drops once the target count is accepted.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, num_vectors       begin a run of num_vectors checks (honoured in IDLE/DONE only)
//   in_valid / in_ready      vector handshake; A, B, C0, S, C_Out, S_ref, C_Out_ref carry the vector
//   vec_count, err_count     vectors compared, mismatches found (err_count saturates)
//   done, pass               run finished; pass = no mismatches in the run
//   fail_A/B/S/C0/C_Out      first failing vector of the run
//
// Optional feature: define CHECKER_FIRST_FAIL_CAPTURE_EN to capture the first
// failing vector on fail_*. Without it, fail_* are constant zero and no
// capture registers exist.

module adder_result_checker #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
   input  logic [WIDTH-1:0] S,
   input  logic             C_Out,
   input  logic [WIDTH-1:0] S_ref,
   input  logic             C_Out_ref,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] fail_A,
   output logic [WIDTH-1:0] fail_B,
   output logic [WIDTH-1:0] fail_S,
   output logic             fail_C0,
   output logic             fail_C_Out
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] target_q;
   logic [CNT_W-1:0] acc_cnt_q;
   logic [CNT_W-1:0] vec_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;

   // Compare stage: one registered vector awaiting comparison.
   logic             stg_vld_q;
   logic [WIDTH-1:0] stg_s_q;
   logic [WIDTH-1:0] stg_s_ref_q;
   logic             stg_co_q;
   logic             stg_co_ref_q;

   logic start_ok;
   logic accept;
   logic last_accept;
   logic mismatch;

   assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
   assign in_ready    = (state_q == RUN) && (acc_cnt_q < target_q);
   assign accept      = in_valid && in_ready;
   assign last_accept = accept && ((acc_cnt_q + CNT_ONE) == target_q);
   assign mismatch    = stg_vld_q && ((stg_s_q != stg_s_ref_q) || (stg_co_q != stg_co_ref_q));

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start_ok) state_d = RUN;
         RUN: begin
            if (target_q == '0)  state_d = DONE;
            else if (last_accept) state_d = DRAIN;
         end
         // Nothing is accepted in DRAIN, so the single compare stage is
         // guaranteed to resolve its last vector on this edge.
         DRAIN: state_d = DONE;
         DONE:  if (start_ok) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ----------------------------------------------------------- counters
   // A start is only honoured while the compare stage is empty, so clearing
   // and counting never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q  <= '0;
         acc_cnt_q <= '0;
         vec_cnt_q <= '0;
         err_cnt_q <= '0;
      end else if (start_ok) begin
         target_q  <= num_vectors;
         acc_cnt_q <= '0;
         vec_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (accept)                            acc_cnt_q <= acc_cnt_q + CNT_ONE;
         if (stg_vld_q)                         vec_cnt_q <= vec_cnt_q + CNT_ONE;
         if (mismatch && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + CNT_ONE;
      end
   end

   // ------------------------------------------------------ compare stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_vld_q    <= 1'b0;
         stg_s_q      <= '0;
         stg_s_ref_q  <= '0;
         stg_co_q     <= 1'b0;
         stg_co_ref_q <= 1'b0;
      end else begin
         stg_vld_q <= accept;
         if (accept) begin
            stg_s_q      <= S;
            stg_s_ref_q  <= S_ref;
            stg_co_q     <= C_Out;
            stg_co_ref_q <= C_Out_ref;
         end
      end
   end

   assign vec_count = vec_cnt_q;
   assign err_count = err_cnt_q;
   assign done      = (state_q == DONE);
   assign pass      = (state_q == DONE) && (err_cnt_q == '0);

   // ---------------------------------------------- first-failure capture
`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
   logic [WIDTH-1:0] stg_a_q, stg_b_q;
   logic             stg_c0_q;
   logic [WIDTH-1:0] cap_a_q, cap_b_q, cap_s_q;
   logic             cap_c0_q, cap_co_q;
   logic             cap_hit_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_a_q  <= '0;
         stg_b_q  <= '0;
         stg_c0_q <= 1'b0;
      end else if (accept) begin
         stg_a_q  <= A;
         stg_b_q  <= B;
         stg_c0_q <= C0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_a_q   <= '0;
         cap_b_q   <= '0;
         cap_s_q   <= '0;
         cap_c0_q  <= 1'b0;
         cap_co_q  <= 1'b0;
         cap_hit_q <= 1'b0;
      end else if (start_ok) begin
         cap_a_q   <= '0;
         cap_b_q   <= '0;
         cap_s_q   <= '0;
         cap_c0_q  <= 1'b0;
         cap_co_q  <= 1'b0;
         cap_hit_q <= 1'b0;
      end else if (mismatch && !cap_hit_q) begin
         // Only the first mismatch of a run is kept; later ones leave it alone.
         cap_a_q   <= stg_a_q;
         cap_b_q   <= stg_b_q;
         cap_s_q   <= stg_s_q;
         cap_c0_q  <= stg_c0_q;
         cap_co_q  <= stg_co_q;
         cap_hit_q <= 1'b1;
      end
   end

   assign fail_A     = cap_a_q;
   assign fail_B     = cap_b_q;
   assign fail_S     = cap_s_q;
   assign fail_C0    = cap_c0_q;
   assign fail_C_Out = cap_co_q;
`else
   // Operands are only needed for capture; fold them into a sink signal.
   logic unused_operands;
   assign unused_operands = ^{A, B, C0};

   assign fail_A     = '0;
   assign fail_B     = '0;
   assign fail_S     = '0;
   assign fail_C0    = 1'b0;
   assign fail_C_Out = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
module tb_adder_result_checker;
   localparam int WIDTH = 64;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_vectors = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] A = '0, B = '0, S = '0, S_ref = '0;
   logic             C0 = 1'b0, C_Out = 1'b0, C_Out_ref = 1'b0;
   logic [CNT_W-1:0] vec_count, err_count;
   logic             done, pass;
   logic [WIDTH-1:0] fail_A, fail_B, fail_S;
   logic             fail_C0, fail_C_Out;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef CHECKER_FIRST_FAIL_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   always #5 clk = ~clk;

   adder_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .C0(C0), .S(S), .C_Out(C_Out), .S_ref(S_ref), .C_Out_ref(C_Out_ref),
      .vec_count(vec_count), .err_count(err_count), .done(done), .pass(pass),
      .fail_A(fail_A), .fail_B(fail_B), .fail_S(fail_S),
      .fail_C0(fail_C0), .fail_C_Out(fail_C_Out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n);
      start = 1'b1;
      num_vectors = n;
      tick();
      start = 1'b0;
   endtask

   task automatic drive_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c0,
                            input logic [WIDTH-1:0] s, input logic co,
                            input logic [WIDTH-1:0] sr, input logic cor);
      A = a; B = b; C0 = c0; S = s; C_Out = co; S_ref = sr; C_Out_ref = cor;
      in_valid = 1'b1;
   endtask

   // Present a vector and hold it until accepted (bounded wait).
   task automatic push_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c0,
                           input logic [WIDTH-1:0] s, input logic co,
                           input logic [WIDTH-1:0] sr, input logic cor);
      int w;
      drive_vec(a, b, c0, s, co, sr, cor);
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin tick(); w++; end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL push_ready: in_ready=%b required 1", in_ready); end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int w;
      w = 0;
      while (done !== 1'b1 && w < 50) begin tick(); w++; end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done_timeout: done=%b required 1", name, done); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
      n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
      n_checks++; if (pass !== 1'b0)      begin n_fail++; $display("FAIL rst_pass: got %b required 0", pass); end
      n_checks++; if (vec_count !== '0)   begin n_fail++; $display("FAIL rst_vec_count: got %0d required 0", vec_count); end
      n_checks++; if (err_count !== '0)   begin n_fail++; $display("FAIL rst_err_count: got %0d required 0", err_count); end
      n_checks++; if ({fail_A, fail_B, fail_S, fail_C0, fail_C_Out} !== '0)
         begin n_fail++; $display("FAIL rst_fail_bus: got %h required 0", {fail_A, fail_B, fail_S, fail_C0, fail_C_Out}); end
      rst_n = 1'b1;
      tick();
      n_checks++; if (done !== 1'b0 || in_ready !== 1'b0)
         begin n_fail++; $display("FAIL rst_release_idle: done=%b in_ready=%b required 0/0", done, in_ready); end
   endtask

   // Three passing vectors on consecutive cycles.
   task automatic test_back_to_back();
      do_start(16'd3);
      for (int i = 0; i < 3; i++) begin
         drive_vec(64'h1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0, 1'b1, 64'h0, 1'b1);
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_no_bubble[%0d]: in_ready=%b required 1", i, in_ready); end
         tick();
      end
      in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_after_target: got %b required 0", in_ready); end
      wait_done("b2b");
      n_checks++; if (vec_count !== 16'd3) begin n_fail++; $display("FAIL b2b_vec_count: got %0d required 3", vec_count); end
      n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL b2b_err_count: got %0d required 0", err_count); end
      n_checks++; if (pass !== 1'b1)       begin n_fail++; $display("FAIL b2b_pass: got %b required 1", pass); end
      n_checks++; if (fail_A !== '0)       begin n_fail++; $display("FAIL b2b_fail_A: got %h required 0", fail_A); end
   endtask

   task automatic test_sum_mismatch();
      logic [WIDTH-1:0] exp_a, exp_b, exp_s;
      exp_a = CAP ? 64'hFFFFFFFFFFFFFFFF : 64'h0;
      exp_b = CAP ? 64'hAAAAAAAAAAAAAAAA : 64'h0;
      exp_s = CAP ? 64'hAAAAAAAAAAAAAAA8 : 64'h0;
      do_start(16'd2);
      push_vec(64'h1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0, 1'b1, 64'h0, 1'b1);
      push_vec(64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA, 1'b0,
               64'hAAAAAAAAAAAAAAA8, 1'b1, 64'hAAAAAAAAAAAAAAA9, 1'b1);
      wait_done("sum");
      n_checks++; if (vec_count !== 16'd2) begin n_fail++; $display("FAIL sum_vec_count: got %0d required 2", vec_count); end
      n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL sum_err_count: got %0d required 1", err_count); end
      n_checks++; if (pass !== 1'b0)       begin n_fail++; $display("FAIL sum_pass: got %b required 0", pass); end
      n_checks++; if (fail_A !== exp_a)    begin n_fail++; $display("FAIL sum_fail_A: got %h required %h", fail_A, exp_a); end
      n_checks++; if (fail_B !== exp_b)    begin n_fail++; $display("FAIL sum_fail_B: got %h required %h", fail_B, exp_b); end
      n_checks++; if (fail_S !== exp_s)    begin n_fail++; $display("FAIL sum_fail_S: got %h required %h", fail_S, exp_s); end
      n_checks++; if (fail_C0 !== 1'b0 || fail_C_Out !== CAP)
         begin n_fail++; $display("FAIL sum_fail_carries: C0=%b C_Out=%b required 0/%b", fail_C0, fail_C_Out, CAP); end
   endtask

   // Sum agrees, only the carry-out differs.
   task automatic test_carry_mismatch();
      logic [WIDTH-1:0] exp_s;
      exp_s = CAP ? 64'h10001 : 64'h0;
      do_start(16'd1);
      push_vec(64'hFF, 64'hFF01, 1'b1, 64'h10001, 1'b1, 64'h10001, 1'b0);
      wait_done("carry");
      n_checks++; if (vec_count !== 16'd1) begin n_fail++; $display("FAIL carry_vec_count: got %0d required 1", vec_count); end
      n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL carry_err_count: got %0d required 1", err_count); end
      n_checks++; if (pass !== 1'b0)       begin n_fail++; $display("FAIL carry_pass: got %b required 0", pass); end
      n_checks++; if (fail_S !== exp_s)    begin n_fail++; $display("FAIL carry_fail_S: got %h required %h", fail_S, exp_s); end
      n_checks++; if (fail_C0 !== CAP || fail_C_Out !== CAP)
         begin n_fail++; $display("FAIL carry_fail_carries: C0=%b C_Out=%b required %b/%b", fail_C0, fail_C_Out, CAP, CAP); end
   endtask

   // Follows the carry test: counters must stay at 1/1 while in_valid is held.
   task automatic test_done_hold();
      drive_vec(64'h5, 64'h5, 1'b0, 64'h1, 1'b0, 64'h2, 1'b1);
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, in_ready); end
         tick();
      end
      in_valid = 1'b0;
      n_checks++; if (vec_count !== 16'd1 || err_count !== 16'd1)
         begin n_fail++; $display("FAIL hold_counts: vec=%0d err=%0d required 1/1", vec_count, err_count); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b required 1", done); end
   endtask

   task automatic test_zero_vectors();
      do_start(16'd0);
      n_checks++; if (in_ready !== 1'b0 || done !== 1'b0)
         begin n_fail++; $display("FAIL zero_run_cycle: in_ready=%b done=%b required 0/0", in_ready, done); end
      tick();
      n_checks++; if (done !== 1'b1)       begin n_fail++; $display("FAIL zero_done: got %b required 1", done); end
      n_checks++; if (pass !== 1'b1)       begin n_fail++; $display("FAIL zero_pass: got %b required 1", pass); end
      n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL zero_in_ready: got %b required 0", in_ready); end
      n_checks++; if (vec_count !== 16'd0) begin n_fail++; $display("FAIL zero_vec_count: got %0d required 0", vec_count); end
   endtask

   task automatic test_reset_midrun();
      do_start(16'd5);
      // A start during RUN must be ignored (a zero target would end the run).
      start = 1'b1;
      num_vectors = 16'd0;
      push_vec(64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 64'h3, 1'b0);
      start = 1'b0;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_start_ignored: in_ready=%b required 1", in_ready); end
      push_vec(64'h4, 64'h4, 1'b0, 64'h8, 1'b0, 64'h8, 1'b0);
      drive_vec(64'h1, 64'h1, 1'b0, 64'h7, 1'b0, 64'h2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
      n_checks++; if (vec_count !== '0)   begin n_fail++; $display("FAIL mid_vec_count: got %0d required 0", vec_count); end
      n_checks++; if (err_count !== '0 || done !== 1'b0 || pass !== 1'b0)
         begin n_fail++; $display("FAIL mid_status: err=%0d done=%b pass=%b required 0/0/0", err_count, done, pass); end
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (vec_count !== '0 || err_count !== '0 || done !== 1'b0)
         begin n_fail++; $display("FAIL mid_idle: vec=%0d err=%0d done=%b required 0/0/0", vec_count, err_count, done); end
      do_start(16'd1);
      push_vec(64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 64'h30, 1'b0);
      wait_done("rerun");
      n_checks++; if (vec_count !== 16'd1 || err_count !== 16'd0 || pass !== 1'b1)
         begin n_fail++; $display("FAIL rerun_result: vec=%0d err=%0d pass=%b required 1/0/1", vec_count, err_count, pass); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_sum_mismatch();
      test_carry_mismatch();
      test_done_hold();
      test_zero_vectors();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
